// File: rtl/wb_channel_arbiter.sv
// Per-channel writeback FIFOs arbitrated onto a single writeback port.
// Round-robin or fixed-priority selection; the grant holds while the consumer stalls.
module wb_channel_arbiter #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ID_WIDTH     = 3,
  parameter int unsigned RR_MODE      = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            ch_valid,
  output logic [NUM_CHANNELS-1:0]            ch_ready,
  input  logic [NUM_CHANNELS*ID_WIDTH-1:0]   ch_id,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  input  logic                               flush,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [ID_WIDTH-1:0]                wb_id,
  output logic [DATA_WIDTH-1:0]              wb_data,
  output logic [$clog2(NUM_CHANNELS)-1:0]    wb_channel,
  output logic                               all_empty
);

  localparam int unsigned CW = $clog2(NUM_CHANNELS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = PW + 1;
  localparam int unsigned EW = ID_WIDTH + DATA_WIDTH;
  localparam logic [NW-1:0] FULL_COUNT = NW'(DEPTH);
  localparam logic [CW-1:0] LAST_CH    = CW'(NUM_CHANNELS - 1);

  logic [EW-1:0]           mem    [NUM_CHANNELS][DEPTH];
  logic [PW-1:0]           wr_ptr [NUM_CHANNELS];
  logic [PW-1:0]           rd_ptr [NUM_CHANNELS];
  logic [NW-1:0]           count  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;
  logic [CW-1:0]           rr_last;
  logic [CW-1:0]           locked_idx;
  logic [CW-1:0]           arb_idx;
  logic [CW-1:0]           scan_ch;
  logic [CW-1:0]           grant;
  logic                    grant_locked;
  logic                    arb_found;
  logic [EW-1:0]           head;

  // Channel visited at search step 'step' (1..NUM_CHANNELS).
  function automatic int unsigned scan_index(input logic [CW-1:0] last,
                                             input int unsigned   step);
    if (RR_MODE != 0) return (32'(last) + step) % NUM_CHANNELS;
    return step - 1;
  endfunction

  always_comb begin
    req      = '0;
    ch_ready = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      req[c]      = (count[c] != '0);
      ch_ready[c] = (count[c] != FULL_COUNT);
    end
  end

  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    scan_ch   = '0;
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      scan_ch = CW'(scan_index(rr_last, i));
      if (!arb_found && req[scan_ch]) begin
        arb_idx   = scan_ch;
        arb_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant      = grant_locked ? locked_idx : arb_idx;
    head       = mem[grant][rd_ptr[grant]];
    wb_valid   = |req;
    all_empty  = ~|req;
    wb_id      = head[EW-1:DATA_WIDTH];
    wb_data    = head[DATA_WIDTH-1:0];
    wb_channel = grant;
  end

  // Flush masks both sides so the pointer/count update below never sees them.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      push[c] = ch_valid[c] & ch_ready[c] & ~flush;
      pop[c]  = wb_valid & wb_ready & ~flush & (grant == CW'(c));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else if (flush) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
        count[c] <= count[c] + NW'(push[c]) - NW'(pop[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c])
        mem[c][wr_ptr[c]] <= {ch_id[c*ID_WIDTH +: ID_WIDTH], ch_data[c*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last      <= LAST_CH;
      grant_locked <= 1'b0;
      locked_idx   <= '0;
    end else if (flush) begin
      rr_last      <= LAST_CH;
      grant_locked <= 1'b0;
      locked_idx   <= '0;
    end else if (wb_valid && !wb_ready) begin
      grant_locked <= 1'b1;
      locked_idx   <= grant;
    end else if (wb_valid && wb_ready) begin
      grant_locked <= 1'b0;
      if (RR_MODE != 0) rr_last <= grant;
    end
  end

endmodule

// File: tb/tb_wb_channel_arbiter.sv
// Bench for wb_channel_arbiter: round-robin and fixed-priority instances share stimulus;
// expectations come from per-channel packet queues and the arbitration rules.
module tb_wb_channel_arbiter;
  localparam int NC = 4;
  localparam int DP = 4;
  localparam int DW = 32;
  localparam int IW = 3;
  typedef logic [IW+DW-1:0] pkt_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] ch_valid = '0;
  logic [NC*IW-1:0] ch_id = '0;
  logic [NC*DW-1:0] ch_data = '0;
  logic          flush = 1'b0;
  logic          wb_ready = 1'b0;

  logic [NC-1:0] rr_ch_ready, fp_ch_ready;
  logic          rr_wb_valid, fp_wb_valid, rr_all_empty, fp_all_empty;
  logic [IW-1:0] rr_wb_id, fp_wb_id;
  logic [DW-1:0] rr_wb_data, fp_wb_data;
  logic [1:0]    rr_wb_channel, fp_wb_channel;

  int checks = 0;
  int errors = 0;

  // Reference: index m*NC+c, m=1 round-robin instance, m=0 fixed-priority instance.
  pkt_t mq [2*NC][$];
  int   mrr [2];
  bit   mlocked [2];
  int   mlidx [2];

  always #5 clk = ~clk;

  wb_channel_arbiter #(.NUM_CHANNELS(NC), .DEPTH(DP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(rr_ch_ready), .ch_id(ch_id),
    .ch_data(ch_data), .flush(flush), .wb_valid(rr_wb_valid), .wb_ready(wb_ready),
    .wb_id(rr_wb_id), .wb_data(rr_wb_data), .wb_channel(rr_wb_channel), .all_empty(rr_all_empty));

  wb_channel_arbiter #(.NUM_CHANNELS(NC), .DEPTH(DP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_ready(fp_ch_ready), .ch_id(ch_id),
    .ch_data(ch_data), .flush(flush), .wb_valid(fp_wb_valid), .wb_ready(wb_ready),
    .wb_id(fp_wb_id), .wb_data(fp_wb_data), .wb_channel(fp_wb_channel), .all_empty(fp_all_empty));

  function automatic void model_clear();
    for (int i = 0; i < 2*NC; i++) mq[i].delete();
    for (int m = 0; m < 2; m++) begin
      mrr[m] = NC - 1;
      mlocked[m] = 1'b0;
      mlidx[m] = 0;
    end
  endfunction

  function automatic int mgrant(int m);
    int c;
    if (mlocked[m]) return mlidx[m];
    for (int i = 1; i <= NC; i++) begin
      c = (m == 1) ? (mrr[m] + i) % NC : i - 1;
      if (mq[m*NC + c].size() != 0) return c;
    end
    return -1;
  endfunction

  function automatic void model_update();
    int   g;
    bit   full [NC];
    pkt_t tmp;
    if (flush) begin
      model_clear();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NC; c++) full[c] = (mq[m*NC + c].size() >= DP);
      g = mgrant(m);
      if (g >= 0) begin
        if (wb_ready) begin
          tmp = mq[m*NC + g].pop_front();
          mrr[m] = g;
          mlocked[m] = 1'b0;
        end else begin
          mlocked[m] = 1'b1;
          mlidx[m] = g;
        end
      end
      for (int c = 0; c < NC; c++)
        if (ch_valid[c] && !full[c]) mq[m*NC + c].push_back({ch_id[c*IW +: IW], ch_data[c*DW +: DW]});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_ch(input int c, input logic [IW-1:0] id, input logic [DW-1:0] data);
    ch_valid[c] = 1'b1;
    ch_id[c*IW +: IW] = id;
    ch_data[c*DW +: DW] = data;
  endtask

  task automatic do_flush();
    ch_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    #2;
    checks++; if (rr_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_rr: got %b want 0", rr_wb_valid); end
    checks++; if (fp_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_fp: got %b want 0", fp_wb_valid); end
    checks++; if (rr_ch_ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %h want f", rr_ch_ready); end
    checks++; if (rr_all_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", rr_all_empty); end
    checks++; if (rr_wb_channel !== 2'd0 || fp_wb_channel !== 2'd0) begin errors++; $display("FAIL reset_channel: got %0d/%0d want 0", rr_wb_channel, fp_wb_channel); end
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    wb_ready = 1'b1;
    set_ch(0, 3'd5, 32'hDEADBEEF);
    tick();
    ch_valid = '0;
    checks++; if (rr_wb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rr_wb_valid); end
    checks++; if (rr_wb_id !== 3'd5 || rr_wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_pkt: got %0d/%h want 5/deadbeef", rr_wb_id, rr_wb_data); end
    checks++; if (rr_wb_channel !== 2'd0 || fp_wb_channel !== 2'd0) begin errors++; $display("FAIL single_channel: got %0d/%0d want 0", rr_wb_channel, fp_wb_channel); end
    checks++; if (rr_all_empty !== 1'b0) begin errors++; $display("FAIL single_nonempty: got %b want 0", rr_all_empty); end
    tick();
    checks++; if (rr_all_empty !== 1'b1 || fp_all_empty !== 1'b1) begin errors++; $display("FAIL single_drained: got %b/%b want 1", rr_all_empty, fp_all_empty); end
    checks++; if (rr_wb_valid !== 1'b0) begin errors++; $display("FAIL single_novalid: got %b want 0", rr_wb_valid); end
  endtask

  task automatic test_rr_fairness();
    do_flush();
    wb_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NC; c++) set_ch(c, 3'(c*2 + r), 32'h100*c + r);
      tick();
    end
    ch_valid = '0;
    wb_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (rr_wb_valid !== 1'b1 || rr_wb_channel !== 2'(k % 4) || rr_wb_id !== 3'((k % 4)*2 + k/4))
        begin errors++; $display("FAIL rr_order k=%0d: got ch%0d id%0d want ch%0d id%0d", k, rr_wb_channel, rr_wb_id, k % 4, (k % 4)*2 + k/4); end
      checks++; if (fp_wb_channel !== 2'(k/2) || fp_wb_id !== 3'((k/2)*2 + k % 2))
        begin errors++; $display("FAIL fp_drain k=%0d: got ch%0d id%0d want ch%0d id%0d", k, fp_wb_channel, fp_wb_id, k/2, (k/2)*2 + k % 2); end
      tick();
    end
    checks++; if (rr_wb_valid !== 1'b0 || fp_wb_valid !== 1'b0) begin errors++; $display("FAIL rr_done: got %b/%b want 0", rr_wb_valid, fp_wb_valid); end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] fp_exp [4];
    logic [1:0] rr_exp [4];
    fp_exp = '{2'd1, 2'd1, 2'd3, 2'd3};
    rr_exp = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_flush();
    wb_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      set_ch(1, 3'(2 + r), 32'hA100 + r);
      set_ch(3, 3'(6 + r), 32'hA300 + r);
      tick();
    end
    ch_valid = '0;
    wb_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (fp_wb_valid !== 1'b1 || fp_wb_channel !== fp_exp[k]) begin errors++; $display("FAIL fp_order k=%0d: got %0d want %0d", k, fp_wb_channel, fp_exp[k]); end
      checks++; if (rr_wb_channel !== rr_exp[k]) begin errors++; $display("FAIL rr_alt k=%0d: got %0d want %0d", k, rr_wb_channel, rr_exp[k]); end
      tick();
    end
    checks++; if (fp_wb_valid !== 1'b0) begin errors++; $display("FAIL fp_done: got %b want 0", fp_wb_valid); end
  endtask

  task automatic test_back_pressure();
    do_flush();
    wb_ready = 1'b0;
    set_ch(2, 3'd4, 32'h2222AAAA);
    tick();
    for (int k = 0; k < 3; k++) begin
      ch_valid = '0;
      if (k == 0) set_ch(0, 3'd1, 32'h00001111);
      if (k == 1) set_ch(3, 3'd6, 32'h33336666);
      checks++; if (rr_wb_channel !== 2'd2 || rr_wb_id !== 3'd4) begin errors++; $display("FAIL lock_rr k=%0d: got ch%0d id%0d want ch2 id4", k, rr_wb_channel, rr_wb_id); end
      checks++; if (fp_wb_channel !== 2'd2 || fp_wb_id !== 3'd4) begin errors++; $display("FAIL lock_fp k=%0d: got ch%0d id%0d want ch2 id4", k, fp_wb_channel, fp_wb_id); end
      tick();
    end
    ch_valid = '0;
    wb_ready = 1'b1;
    checks++; if (rr_wb_channel !== 2'd2 || fp_wb_channel !== 2'd2) begin errors++; $display("FAIL lock_hold: got %0d/%0d want 2", rr_wb_channel, fp_wb_channel); end
    tick();
    checks++; if (rr_wb_channel !== 2'd3 || rr_wb_id !== 3'd6) begin errors++; $display("FAIL after_lock_rr: got ch%0d want ch3", rr_wb_channel); end
    checks++; if (fp_wb_channel !== 2'd0 || fp_wb_id !== 3'd1) begin errors++; $display("FAIL after_lock_fp: got ch%0d want ch0", fp_wb_channel); end
    tick();
    checks++; if (rr_wb_channel !== 2'd0 || fp_wb_channel !== 2'd3) begin errors++; $display("FAIL after_lock2: got %0d/%0d want 0/3", rr_wb_channel, fp_wb_channel); end
    tick();
    checks++; if (rr_wb_valid !== 1'b0) begin errors++; $display("FAIL lock_done: got %b want 0", rr_wb_valid); end
  endtask

  task automatic test_full_wrap();
    do_flush();
    wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ch_valid = '0;
      set_ch(1, 3'(k), 32'hC0DE0000 + k);
      tick();
    end
    ch_valid = '0;
    checks++; if (rr_ch_ready[1] !== 1'b0 || fp_ch_ready[1] !== 1'b0) begin errors++; $display("FAIL full_ready: got %b/%b want 0", rr_ch_ready[1], fp_ch_ready[1]); end
    checks++; if (rr_wb_id !== 3'd0) begin errors++; $display("FAIL full_head: got %0d want 0", rr_wb_id); end
    set_ch(1, 3'd4, 32'hC0DE0004);
    wb_ready = 1'b1;
    tick();
    ch_valid = '0;
    checks++; if (rr_ch_ready[1] !== 1'b1) begin errors++; $display("FAIL full_popped_ready: got %b want 1", rr_ch_ready[1]); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (rr_wb_valid !== 1'b1 || rr_wb_id !== 3'(k) || rr_wb_data !== 32'hC0DE0000 + k)
        begin errors++; $display("FAIL full_drain k=%0d: got id%0d %h want id%0d", k, rr_wb_id, rr_wb_data, k); end
      tick();
    end
    checks++; if (rr_wb_valid !== 1'b0) begin errors++; $display("FAIL fifth_dropped: got %b want 0", rr_wb_valid); end
    for (int k = 0; k < 6; k++) begin
      ch_valid = '0;
      set_ch(1, 3'((k + 5) % 8), 32'hBEEF0000 + k);
      tick();
      checks++; if (rr_wb_valid !== 1'b1 || rr_wb_data !== 32'hBEEF0000 + k || fp_wb_data !== 32'hBEEF0000 + k)
        begin errors++; $display("FAIL wrap_order k=%0d: got %h/%h want %h", k, rr_wb_data, fp_wb_data, 32'hBEEF0000 + k); end
    end
    ch_valid = '0;
    tick();
    checks++; if (rr_wb_valid !== 1'b0) begin errors++; $display("FAIL wrap_done: got %b want 0", rr_wb_valid); end
  endtask

  task automatic test_flush();
    do_flush();
    wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) set_ch(c, 3'(c), 32'hF0 + c);
    tick();
    ch_valid = '0;
    checks++; if (rr_all_empty !== 1'b0) begin errors++; $display("FAIL preflush_empty: got %b want 0", rr_all_empty); end
    flush = 1'b1;
    wb_ready = 1'b1;
    set_ch(0, 3'd7, 32'h77777777);
    tick();
    flush = 1'b0;
    ch_valid = '0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rr_wb_valid !== 1'b0 || fp_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid k=%0d: got %b/%b want 0", k, rr_wb_valid, fp_wb_valid); end
      checks++; if (rr_all_empty !== 1'b1) begin errors++; $display("FAIL flush_empty k=%0d: got %b want 1", k, rr_all_empty); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    do_flush();
    wb_ready = 1'b0;
    set_ch(1, 3'd3, 32'h12345678);
    set_ch(2, 3'd2, 32'h87654321);
    tick();
    ch_valid = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rr_wb_valid !== 1'b0 || fp_wb_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b/%b want 0", rr_wb_valid, fp_wb_valid); end
    checks++; if (rr_ch_ready !== 4'hF || rr_all_empty !== 1'b1) begin errors++; $display("FAIL midreset_state: got %h/%b want f/1", rr_ch_ready, rr_all_empty); end
    model_clear();
    #2 rst_n = 1'b1;
    wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rr_wb_valid !== 1'b0 || fp_wb_valid !== 1'b0) begin errors++; $display("FAIL postreset_valid k=%0d: got %b/%b want 0", k, rr_wb_valid, fp_wb_valid); end
    end
  endtask

  task automatic test_random();
    int         g;
    pkt_t       h;
    logic       dv, de;
    logic [1:0] dch;
    logic [IW-1:0] did;
    logic [DW-1:0] dd;
    logic [NC-1:0] dr, er;
    do_flush();
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        g   = mgrant(m);
        dv  = (m == 1) ? rr_wb_valid   : fp_wb_valid;
        de  = (m == 1) ? rr_all_empty  : fp_all_empty;
        dch = (m == 1) ? rr_wb_channel : fp_wb_channel;
        did = (m == 1) ? rr_wb_id      : fp_wb_id;
        dd  = (m == 1) ? rr_wb_data    : fp_wb_data;
        dr  = (m == 1) ? rr_ch_ready   : fp_ch_ready;
        for (int c = 0; c < NC; c++) er[c] = (mq[m*NC + c].size() < DP);
        checks++; if (dv !== (g >= 0)) begin errors++; $display("FAIL rand_valid m=%0d i=%0d: got %b want %b", m, i, dv, g >= 0); end
        checks++; if (de !== (g < 0)) begin errors++; $display("FAIL rand_empty m=%0d i=%0d: got %b want %b", m, i, de, g < 0); end
        checks++; if (dr !== er) begin errors++; $display("FAIL rand_ready m=%0d i=%0d: got %h want %h", m, i, dr, er); end
        if (g >= 0) begin
          h = mq[m*NC + g][0];
          checks++; if (dch !== 2'(g) || {did, dd} !== h)
            begin errors++; $display("FAIL rand_pkt m=%0d i=%0d: got ch%0d %h want ch%0d %h", m, i, dch, {did, dd}, g, h); end
        end
      end
      ch_valid = 4'($urandom);
      ch_id    = 12'($urandom);
      ch_data  = {$urandom, $urandom, $urandom, $urandom};
      wb_ready = ($urandom % 100) < ((i % 200) < 100 ? 35 : 85);
      flush    = ($urandom % 60) == 0;
      tick();
    end
    ch_valid = '0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_rr_fairness();
    test_fixed_priority();
    test_back_pressure();
    test_full_wrap();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
